mole_scheduler: RTL and testbench
=================================

Name: mole_scheduler

Overview:
- Parametrised successor to the single-light game controller.
- Drives NUM_LIGHTS mole LEDs from an internal 16-bit LFSR, with runtime-programmable gap and on-time durations.
- Detects player button presses: correct hits, wrong presses and timeouts, each reported as a one-cycle pulse.
- Sits between the game FSM (start/stop, durations) and the LED/button board I/O.

Parameters:
- NUM_LIGHTS, 9, number of lights/buttons; legal range 2..16.
- CNT_W, 28, width of the duration counters and duration inputs.
- IDX_W, 4, index width; must equal clog2(NUM_LIGHTS).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE only.
- stop  in  1  level; abort to IDLE from any state.
- gap_cycles  in  CNT_W  all-off time between moles.
- on_cycles  in  CNT_W  maximum mole visible time.
- seed  in  16  LFSR seed.
- seed_load  in  1  load seed into the LFSR this cycle.
- buttons  in  NUM_LIGHTS  active-high, already synchronised to CLOCK_50.
- lights  out  NUM_LIGHTS  registered; one-hot or zero.
- cur_idx  out  IDX_W  index of the current or last mole.
- hit  out  1  one-cycle pulse, correct press.
- miss  out  1  one-cycle pulse, on-time expired.
- wrong  out  1  one-cycle pulse, press on an unlit button.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset values: lights=0, cur_idx=0, hit=miss=wrong=0, busy=0, state=IDLE, LFSR=16'hACE1, counter=0, prev_buttons=0.
- LFSR:
  - Fibonacci, shifts left every cycle in every state; feedback bit = q[15]^q[13]^q[12]^q[10].
  - seed_load has priority over shifting. A seed of 0 loads 16'hACE1 instead.
- Index selection: raw = lfsr[IDX_W-1:0]; idx = raw >= NUM_LIGHTS ? raw - NUM_LIGHTS : raw. One subtraction always suffices.
- Button edges: press = buttons & ~prev_buttons, where prev_buttons is registered every cycle.
- States and transitions:
  - IDLE: lights=0. If start and not stop, latch gap_cycles and on_cycles into shadow registers and go to GAP. Durations are not re-sampled until the next start.
  - GAP:
    - Lights are all off; counter counts down.
    - GAP lasts exactly max(gap,1) cycles.
    - On the last GAP cycle, choose idx, register cur_idx=idx, and set lights to one-hot(idx) on the following edge. Enter SHOW at that same edge.
  - SHOW: counter counts down from max(on,1). Each cycle, evaluate in priority order:
    1. press[cur_idx]: hit=1, lights cleared next edge, go to GAP. The counter is not checked.
    2. Counter expiry on the last cycle: miss=1, lights cleared, go to GAP.
    3. Any press on a bit other than cur_idx: wrong=1 and remain in SHOW. wrong is suppressed in any cycle where hit is asserted.
- Pulses are registered: asserted the cycle after the causing edge, for exactly one cycle.
- Presses outside SHOW are ignored and generate no pulses.
- Holding a button generates only one press.
- Duration of 0 is treated as 1 cycle (no stall, no underflow).
- stop:
  - From any state, next edge goes to IDLE, lights=0, and no pulse is generated in that cycle.
  - stop has priority over start and over hit/miss on the same cycle.
  - cur_idx retains its value.
- Mid-operation reset: immediate asynchronous return to the reset values listed above; lights drop without waiting for a clock edge.

Optional Feature:
- Macro: MOLE_NO_REPEAT_EN.
- Defined: if the chosen idx equals the previous cur_idx, use (idx+1) wrapped at NUM_LIGHTS, so the same light is never chosen twice in a row. The first mole after reset or IDLE compares against cur_idx as held.
- Undefined: the raw selected idx is used; repeats are allowed.

Test Plan:
- Reset then seed_load seed=16'h0000 -> LFSR reads 16'hACE1; lights=0, busy=0.
- gap=3, on=5, start pulse, no buttons -> lights one-hot exactly 3 cycles after GAP entry, held 5 cycles, then miss pulse; repeats indefinitely.
- During SHOW with cur_idx=4, buttons[4] rises on cycle 2 -> hit pulse next cycle, lights=0, new GAP of 3 cycles starts.
- During SHOW with cur_idx=4, buttons[1] rises, then held 10 cycles -> exactly one wrong pulse; light 4 stays lit; miss follows at expiry.
- buttons[cur_idx] rises on the last SHOW cycle -> hit only, no miss. Same cycle with stop high -> IDLE, no pulse.
- NUM_LIGHTS=9 with raw index 12 -> idx 3. With MOLE_NO_REPEAT_EN and forced previous idx 8, new idx 8 -> 0.

Source files
------------

// File: rtl/mole_scheduler.sv
// mole_scheduler: LFSR-driven multi-light whack-a-mole scheduler.
// Takes the game FSM's start/stop and the gap/on durations. Drives one mole
// LED at a time and reports hit / miss / wrong presses as one-cycle pulses.
// Optional build macro: MOLE_NO_REPEAT_EN. When it is defined, the same light
// is never chosen twice in a row.
module mole_scheduler #(
  parameter int NUM_LIGHTS = 9,
  parameter int CNT_W      = 28,
  parameter int IDX_W      = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_W-1:0]      gap_cycles,
  input  logic [CNT_W-1:0]      on_cycles,
  input  logic [15:0]           seed,
  input  logic                  seed_load,
  input  logic [NUM_LIGHTS-1:0] buttons,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [IDX_W-1:0]      cur_idx,
  output logic                  hit,
  output logic                  miss,
  output logic                  wrong,
  output logic                  busy
);

  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  typedef enum logic [1:0] {IDLE = 2'd0, GAP = 2'd1, SHOW = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [15:0]           lfsr;
  logic [CNT_W-1:0]      counter, counter_nxt;
  logic [CNT_W-1:0]      gap_sh, on_sh;
  logic                  load_sh;
  logic [NUM_LIGHTS-1:0] prev_buttons, press, cur_mask, lights_nxt;
  logic [IDX_W-1:0]      sel_idx, cur_idx_nxt;
  logic                  hit_nxt, miss_nxt, wrong_nxt;
  logic                  cnt_zero, hit_cond, wrong_cond;

  // Raw LFSR bits span at most 2*NUM_LIGHTS-1, so one subtraction folds them.
  function automatic logic [IDX_W-1:0] fold_idx(input logic [IDX_W-1:0] raw);
    if (int'(raw) >= NUM_LIGHTS) return raw - IDX_W'(NUM_LIGHTS);
    else                         return raw;
  endfunction

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
    if (int'(idx) == NUM_LIGHTS - 1) return '0;
    else                             return idx + IDX_W'(1);
  endfunction

  function automatic logic [NUM_LIGHTS-1:0] one_hot(input logic [IDX_W-1:0] idx);
    return NUM_LIGHTS'(1) << idx;
  endfunction

  // The counter runs from max(d,1)-1 down to 0, so a zero duration still lasts one cycle.
  function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - CNT_W'(1);
  endfunction

  assign press      = buttons & ~prev_buttons;
  assign cur_mask   = one_hot(cur_idx);
  assign cnt_zero   = (counter == '0);
  assign hit_cond   = |(press & cur_mask);
  assign wrong_cond = |(press & ~cur_mask);
  assign busy       = (state != IDLE);

  // Pick the next mole from the LFSR and optionally step it off the previous light.
  always_comb begin
    sel_idx = fold_idx(lfsr[IDX_W-1:0]);
`ifdef MOLE_NO_REPEAT_EN
    if (sel_idx == cur_idx) sel_idx = wrap_inc(sel_idx);
`endif
  end

  // Free-running LFSR. A seed load wins over shifting, and a zero seed would lock up.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)         lfsr <= LFSR_INIT;
    else if (seed_load) lfsr <= (seed == 16'h0000) ? LFSR_INIT : seed;
    else                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic. stop overrides everything else.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = GAP;
        GAP:     if (cnt_zero) state_nxt = SHOW;
        SHOW:    if (hit_cond || cnt_zero) state_nxt = GAP;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values for the registered outputs and the duration counter.
  always_comb begin
    counter_nxt = counter;
    lights_nxt  = lights;
    cur_idx_nxt = cur_idx;
    hit_nxt     = 1'b0;
    miss_nxt    = 1'b0;
    wrong_nxt   = 1'b0;
    load_sh     = 1'b0;
    if (stop) begin
      lights_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          lights_nxt = '0;
          if (start) begin
            load_sh     = 1'b1;
            counter_nxt = last_cnt(gap_cycles);
          end
        end
        GAP: begin
          lights_nxt = '0;
          if (cnt_zero) begin
            cur_idx_nxt = sel_idx;
            lights_nxt  = one_hot(sel_idx);
            counter_nxt = last_cnt(on_sh);
          end else begin
            counter_nxt = counter - CNT_W'(1);
          end
        end
        SHOW: begin
          if (hit_cond) begin
            hit_nxt     = 1'b1;
            lights_nxt  = '0;
            counter_nxt = last_cnt(gap_sh);
          end else if (cnt_zero) begin
            miss_nxt    = 1'b1;
            lights_nxt  = '0;
            counter_nxt = last_cnt(gap_sh);
          end else begin
            wrong_nxt   = wrong_cond;
            counter_nxt = counter - CNT_W'(1);
          end
        end
        default: lights_nxt = '0;
      endcase
    end
  end

  // Registered outputs, counter, duration shadows and the button edge history.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lights       <= '0;
      cur_idx      <= '0;
      hit          <= 1'b0;
      miss         <= 1'b0;
      wrong        <= 1'b0;
      counter      <= '0;
      gap_sh       <= '0;
      on_sh        <= '0;
      prev_buttons <= '0;
    end else begin
      lights       <= lights_nxt;
      cur_idx      <= cur_idx_nxt;
      hit          <= hit_nxt;
      miss         <= miss_nxt;
      wrong        <= wrong_nxt;
      counter      <= counter_nxt;
      prev_buttons <= buttons;
      if (load_sh) begin
        gap_sh <= gap_cycles;
        on_sh  <= on_cycles;
      end
    end
  end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler (NUM_LIGHTS=9).
// Expected mole indices are pushed to a queue when stimulus is driven and popped when a mole lights.
`timescale 1ns/1ps
module tb_mole_scheduler;
  localparam int NL = 9;
  localparam int CW = 28;
  localparam int IW = 4;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] gap_cycles = '0;
  logic [CW-1:0] on_cycles = '0;
  logic [15:0]   seed = '0;
  logic          seed_load = 1'b0;
  logic [NL-1:0] buttons = '0;
  logic [NL-1:0] lights;
  logic [IW-1:0] cur_idx;
  logic          hit, miss, wrong, busy;

  mole_scheduler #(.NUM_LIGHTS(NL), .CNT_W(CW), .IDX_W(IW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .start(start), .stop(stop),
    .gap_cycles(gap_cycles), .on_cycles(on_cycles), .seed(seed),
    .seed_load(seed_load), .buttons(buttons), .lights(lights),
    .cur_idx(cur_idx), .hit(hit), .miss(miss), .wrong(wrong), .busy(busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int last_pushed = 0;
  int cur = 0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lf_shift(input logic [15:0] q);
    return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  endfunction

  function automatic int ref_idx(input logic [15:0] l, input int prev);
    int r;
    r = int'(l[3:0]);
    if (r >= NL) r = r - NL;
`ifdef MOLE_NO_REPEAT_EN
    if (r == prev) r = (r + 1) % NL;
`endif
    return r;
  endfunction

  // Reference LFSR, following the same inputs as the DUT.
  always @(posedge CLOCK_50 or negedge reset) begin
    if (!reset)         m_lfsr <= 16'hACE1;
    else if (seed_load) m_lfsr <= (seed == 16'h0000) ? 16'hACE1 : seed;
    else                m_lfsr <= lf_shift(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Called on the negedge just before the edge that enters GAP with duration g.
  task automatic push_exp(input int g);
    logic [15:0] l;
    int n;
    int e;
    l = m_lfsr;
    n = (g < 1) ? 1 : g;
    repeat (n) l = lf_shift(l);
    e = ref_idx(l, last_pushed);
    exp_q.push_back(e);
    last_pushed = e;
  endtask

  task automatic push_const(input int e);
    exp_q.push_back(e);
    last_pushed = e;
  endtask

  // Called on the negedge just after the GAP-entry edge. Waits for the mole to light.
  task automatic wait_mole(input string tag, input int g);
    int cnt;
    logic pulse;
    logic [NL-1:0] m;
    cnt = 0;
    pulse = 1'b0;
    while (lights == '0 && cnt < 40) begin
      step();
      cnt++;
      pulse = pulse | hit | miss | wrong;
    end
    check({tag, "_gap_len"}, cnt, g);
    check({tag, "_no_pulse"}, {31'd0, pulse}, 32'd0);
    check({tag, "_queue"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      m = '0;
      m[cur] = 1'b1;
      check({tag, "_idx"}, cur_idx, cur);
      check({tag, "_lights"}, lights, m);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lit;
    int wrongs;
    logic misses;
    logic [NL-1:0] m;
    int w;

    // Reset state
    step(2);
    check("rst_lights", lights, 0);
    check("rst_cur_idx", cur_idx, 0);
    check("rst_pulses", {29'd0, hit, miss, wrong}, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;

    // Zero seed loads the default value
    seed = 16'h0000;
    seed_load = 1'b1;
    step();
    seed_load = 1'b0;
    check("seed0_lfsr", dut.lfsr, 16'hACE1);
    check("idle_lights", lights, 0);
    check("idle_busy", busy, 0);

    // gap=3, on=5, no buttons: mole after 3 cycles, lit 5 cycles, then miss
    gap_cycles = 3;
    on_cycles = 5;
    start = 1'b1;
    push_exp(3);
    step();
    start = 1'b0;
    check("start_busy", busy, 1);
    wait_mole("m1", 3);
    m = '0; m[cur] = 1'b1;
    lit = 0; misses = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (lights == m) lit++;
      misses = misses | miss;
    end
    check("m1_held", lit, 4);
    check("m1_early_miss", misses, 0);
    push_exp(3);
    step();
    check("m1_miss", miss, 1);
    check("m1_miss_lights", lights, 0);
    check("m1_miss_hit", hit, 0);
    wait_mole("m2", 3);

    // Hit on SHOW cycle 2
    step();
    buttons = '0; buttons[cur] = 1'b1;
    push_exp(3);
    step();
    check("hit_pulse", hit, 1);
    check("hit_no_miss", miss, 0);
    check("hit_no_wrong", wrong, 0);
    check("hit_lights", lights, 0);
    buttons = '0;
    wait_mole("m3", 3);

    // Wrong button held: one wrong pulse, light stays, then miss
    step();
    w = (cur + 1) % NL;
    buttons = '0; buttons[w] = 1'b1;
    m = '0; m[cur] = 1'b1;
    wrongs = 0; lit = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      wrongs += int'(wrong);
      if (lights == m) lit++;
    end
    push_exp(3);
    step();
    check("wrong_count", wrongs, 1);
    check("wrong_lit", lit, 3);
    check("wrong_then_miss", miss, 1);
    check("wrong_late", wrong, 0);
    // Presses during GAP are ignored
    buttons = '1;
    wait_mole("m4", 3);

    // Press on the last SHOW cycle: hit only
    buttons = '0;
    step(4);
    buttons[cur] = 1'b1;
    push_exp(3);
    step();
    check("last_hit", hit, 1);
    check("last_no_miss", miss, 0);
    buttons = '0;
    wait_mole("m5", 3);

    // Same on the last cycle with stop: IDLE, no pulse, cur_idx kept
    step(4);
    buttons[cur] = 1'b1;
    stop = 1'b1;
    step();
    check("stop_pulses", {29'd0, hit, miss, wrong}, 0);
    check("stop_busy", busy, 0);
    check("stop_lights", lights, 0);
    check("stop_cur_idx", cur_idx, cur);
    stop = 1'b0;
    buttons = '1;
    step();
    check("idle_press_pulses", {29'd0, hit, miss, wrong}, 0);
    check("idle_stays", busy, 0);
    buttons = '0;
    step();

    // Zero durations act as one cycle; inputs changed mid-run are not re-sampled
    gap_cycles = 0;
    on_cycles = 0;
    start = 1'b1;
    push_exp(1);
    step();
    start = 1'b0;
    gap_cycles = 7;
    on_cycles = 7;
    wait_mole("d0a", 1);
    push_exp(1);
    step();
    check("d0_miss", miss, 1);
    wait_mole("d0b", 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Raw index 12 folds to 3
    gap_cycles = 1;
    on_cycles = 5;
    seed = 16'h000C;
    seed_load = 1'b1;
    start = 1'b1;
`ifdef MOLE_NO_REPEAT_EN
    push_const((last_pushed == 3) ? 4 : 3);
`else
    push_const(3);
`endif
    step();
    seed_load = 1'b0;
    start = 1'b0;
    wait_mole("raw12", 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Raw index 8 twice in a row
    seed = 16'h0008;
    seed_load = 1'b1;
    start = 1'b1;
    push_const(8);
    step();
    seed_load = 1'b0;
    start = 1'b0;
    wait_mole("raw8a", 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    seed_load = 1'b1;
    start = 1'b1;
`ifdef MOLE_NO_REPEAT_EN
    push_const(0);
`else
    push_const(8);
`endif
    step();
    seed_load = 1'b0;
    start = 1'b0;
    wait_mole("raw8b", 1);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Mid-operation reset drops everything without a clock edge
    gap_cycles = 2;
    on_cycles = 5;
    start = 1'b1;
    push_exp(2);
    step();
    start = 1'b0;
    wait_mole("pre_rst", 2);
    #2 reset = 1'b0;
    #1;
    check("arst_lights", lights, 0);
    check("arst_busy", busy, 0);
    check("arst_cur_idx", cur_idx, 0);
    step();
    reset = 1'b1;
    step();
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
